// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM playback path.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    RAMP
  } pwm_state_t;

  localparam logic [7:0] PWM_MIDSCALE           = 8'h80;
  localparam int         PWM_SAMPLE_DIV_DEFAULT = 2500;

  // One ramp step toward midscale; midscale itself is a fixed point.
  function automatic logic [7:0] step_to_mid(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (s > PWM_MIDSCALE) begin
      r = s - 8'd1;
    end else if (s < PWM_MIDSCALE) begin
      r = s + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser with synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pwm_playback_ctrl.sv
// Tick-paced playback from the show-ahead PWM FIFO into the 8-bit DAC sample,
// with underrun handling and click-free ramps to midscale on start/stop.
module pwm_playback_ctrl
  import pwm_pkg::*;
#(
  parameter int          SAMPLE_DIV     = PWM_SAMPLE_DIV_DEFAULT,
  parameter int          DIV_WIDTH      = 12,
  parameter int          UNDERRUN_LIMIT = 4,
  // Reset value of the underrun counter; nonzero only for bring-up of the saturation path.
  parameter logic [15:0] UNDERRUN_INIT  = 16'h0000
) (
  input  logic        pwmclk,
  input  logic        RESET,
  input  logic        enable,
  input  logic        fifo_empty_n,
  input  logic [15:0] fifo_data,
  output logic        fifo_rd,
  output logic [7:0]  sample,
  output logic        sample_strobe,
  output logic [15:0] underrun_count,
  output logic        active
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(SAMPLE_DIV - 1);
  localparam logic [7:0]           LIMIT    = 8'(UNDERRUN_LIMIT);

  pwm_state_t           state_reg, state_next;
  logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
  logic [7:0]           sample_reg, sample_next;
  logic                 rd_reg, rd_next;
  logic                 strobe_reg, strobe_next;
  logic [15:0]          underrun_reg, underrun_next;
  logic [7:0]           consec_reg, consec_next;

  logic                 en_s;
  logic                 tick;
  logic [7:0]           stepped;
  logic [7:0]           consec_inc;
  logic                 unused_fifo_bits;

  sync_2ff u_enable_sync (
    .clk   (pwmclk),
    .rst_n (RESET),
    .d     (enable),
    .q     (en_s)
  );

  assign tick             = (cnt_reg == DIV_LAST);
  assign stepped          = step_to_mid(sample_reg);
  assign consec_inc       = consec_reg + 8'd1;
  assign unused_fifo_bits = ^{fifo_data[15:12], fifo_data[3:0]};

  always_ff @(posedge pwmclk) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      sample_reg   <= PWM_MIDSCALE;
      rd_reg       <= 1'b0;
      strobe_reg   <= 1'b0;
      underrun_reg <= UNDERRUN_INIT;
      consec_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sample_reg   <= sample_next;
      rd_reg       <= rd_next;
      strobe_reg   <= strobe_next;
      underrun_reg <= underrun_next;
      consec_reg   <= consec_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    sample_next   = sample_reg;
    rd_next       = 1'b0;
    strobe_next   = 1'b0;
    underrun_next = underrun_reg;
    consec_next   = consec_reg;

    case (state_reg)
      IDLE: begin
        cnt_next    = '0;
        sample_next = PWM_MIDSCALE;
        consec_next = '0;
        if (en_s) begin
          state_next = PRIME;
        end else if (fifo_empty_n) begin
          // Alternate-cycle flush so the FIFO's empty flag settles between pops.
          rd_next = !rd_reg;
        end
      end

      PRIME: begin
        // Holding at the last count makes the first RUN cycle a tick.
        cnt_next = DIV_LAST;
        if (!en_s) begin
          state_next = RAMP;
        end else if (fifo_empty_n) begin
          state_next = RUN;
        end
      end

      RUN: begin
        cnt_next = tick ? '0 : cnt_reg + DIV_WIDTH'(1);
        if (tick) begin
          strobe_next = 1'b1;
          if (fifo_empty_n) begin
            rd_next     = 1'b1;
            sample_next = fifo_data[11:4];
            consec_next = '0;
          end else begin
            if (underrun_reg != 16'hFFFF) begin
              underrun_next = underrun_reg + 16'd1;
            end
            consec_next = consec_inc;
            if (consec_inc >= LIMIT) begin
              state_next = RAMP;
            end
          end
        end
        if (!en_s) begin
          state_next = RAMP;
        end
      end

      RAMP: begin
        cnt_next = tick ? '0 : cnt_reg + DIV_WIDTH'(1);
        if (tick) begin
          strobe_next = 1'b1;
          sample_next = stepped;
          if (stepped == PWM_MIDSCALE) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fifo_rd        = rd_reg;
  assign sample         = sample_reg;
  assign sample_strobe  = strobe_reg;
  assign underrun_count = underrun_reg;
  assign active         = (state_reg != IDLE);

endmodule

// File: doc/pwm_playback_ctrl.md
# pwm_playback_ctrl

Paces playback from the PWM sample FIFO into the PWM DAC at a fixed sample rate in the `pwmclk` domain. It replaces free-running FIFO draining with tick-driven pops and converts 16-bit FIFO words to the 8-bit DAC sample. It handles FIFO underrun and ramps the output to midscale on start/stop to suppress clicks. It sits between the read side of the PWM FIFO and the `sample` input of the PWM DAC.

## Interface
Parameters:
- `SAMPLE_DIV`, 2500: `pwmclk` cycles per output sample (110 MHz / 44 kHz); minimum 4.
- `DIV_WIDTH`, 12: width of the tick counter; must satisfy 2^DIV_WIDTH >= SAMPLE_DIV.
- `UNDERRUN_LIMIT`, 4: number of consecutive empty ticks that forces a ramp-down; range 1..255.

Ports:
- `pwmclk`, in, 1: clock.
- `RESET`, in, 1: reset; synchronous, active-low.
- `enable`, in, 1: play request; asynchronous to `pwmclk`; synchronised internally.
- `fifo_empty_n`, in, 1: FIFO has data. The FIFO is show-ahead: `fifo_data` is valid whenever this is high.
- `fifo_data`, in, 16: head FIFO word; bits [11:4] carry the sample.
- `fifo_rd`, out, 1: one-cycle pop. The FIFO must ignore pops while empty.
- `sample`, out, 8: DAC sample.
- `sample_strobe`, out, 1: one-cycle pulse when `sample` is updated.
- `underrun_count`, out, 16: saturating count of underrun ticks.
- `active`, out, 1: high when the state is not IDLE.

## Operation
- `enable` is passed through a 2-flop synchroniser to produce `en_s`.
- Tick counter:
  - In PRIME it is held at SAMPLE_DIV-1.
  - In RUN and RAMP it counts 0..SAMPLE_DIV-1 and wraps to 0.
  - `tick` is asserted when the counter equals SAMPLE_DIV-1.
  - In IDLE it is held at 0.
- IDLE:
  - `sample` is held at 0x80.
  - If `en_s` is low and `fifo_empty_n` is high, the block flushes: `fifo_rd` is pulsed on alternate cycles so stale words are discarded without popping an empty FIFO.
  - `en_s` high moves to PRIME.
- PRIME:
  - Waits for `fifo_empty_n`, then moves to RUN.
  - `en_s` low moves to RAMP.
- RUN, on each `tick`:
  - If `fifo_empty_n` is high: pop the FIFO, load `sample` from `fifo_data[11:4]`, and clear the consecutive-underrun counter.
  - If `fifo_empty_n` is low: hold `sample`, increment `underrun_count` (saturating at 0xFFFF), and increment the consecutive-underrun counter. When that counter reaches UNDERRUN_LIMIT, move to RAMP.
  - `en_s` low moves to RAMP at any cycle, tick or not. If a tick and `en_s` low occur in the same cycle, that tick's pop is still performed.
- RAMP:
  - On each `tick`, `sample` steps by 1 toward 0x80.
  - On the tick where `sample` reaches 0x80, move to IDLE. If `sample` is already 0x80 on entry, the next tick moves to IDLE.
  - No pops occur in RAMP.
  - `en_s` is ignored until IDLE is reached.
- `sample_strobe` pulses for every RUN tick and every RAMP tick.

## Timing
- Reset values: `sample`=0x80, `fifo_rd`=0, `sample_strobe`=0, `underrun_count`=0, `active`=0. State is IDLE, counters are 0, and the synchroniser flops are 0.
- A reset asserted in any state takes effect at the next edge.
- `enable` to state change: 2 cycles through the synchroniser plus 1 cycle for the transition.
- A PRIME→RUN transition makes the first RUN cycle a tick. Subsequent ticks occur every SAMPLE_DIV cycles.
- All outputs are registered. For a tick in cycle t:
  - `fifo_rd`, `sample_strobe` and the new `sample` are visible in cycle t+1.
  - The `fifo_data` captured is the value present in cycle t.
- `fifo_rd` is never high in two consecutive cycles.
- `active` falls in the cycle after the last RAMP tick.

## Structure
- Shared package `pwm_pkg` holds:
  - the state typedef: IDLE, PRIME, RUN, RAMP;
  - `PWM_MIDSCALE` = 8'h80;
  - `PWM_SAMPLE_DIV_DEFAULT` = 2500.
- Sub-module `sync_2ff`: a 1-bit two-flop synchroniser used for `enable`, reusable elsewhere.

## Test plan
- Reset → all outputs hold their reset values. Pulse `RESET` low during RAMP → the next cycle shows the reset values and `active`=0.
- Playback (SAMPLE_DIV=8): FIFO preloaded with 0x0120, 0x0FF0, 0x0800, `enable`=1 → three pops 8 cycles apart producing `sample` 0x12, 0xFF, 0x80, each with `sample_strobe`.
- Underrun (UNDERRUN_LIMIT=4): FIFO empties after 0x0FF0 → `sample` holds 0xFF for 4 ticks and `underrun_count`=4. Then 127 RAMP ticks down to 0x80, then IDLE and `active`=0.
- Stop mid-RUN with `sample`=0x10 → 112 RAMP ticks up to 0x80 with no `fifo_rd`. Then IDLE flushes 5 queued words in 10 cycles, with `fifo_rd` on alternate cycles.
- `enable` toggled high during RAMP → the ramp completes, IDLE lasts 1 cycle, then PRIME. `enable` dropped during PRIME → RAMP, and the IDLE after it occurs on the first tick since `sample`=0x80.
- Saturation: `underrun_count` preloaded to 0xFFFE, then 3 underrun ticks → reads 0xFFFF.
